neuron_mac: RTL and testbench

Single-neuron multiply-accumulate stage that consumes the 8-bit pixel byte stream produced by the block-memory read stage.
- Each accepted byte is multiplied by the signed weight at the current input index, held in an internal weight store.
- After N_INPUTS bytes the block adds the bias, applies ReLU, requantizes to OUT_W bits and presents one activation on a valid/ready output.
- Feeds the next layer's input buffer.

---
 rtl/neuron_mac_if.sv | 45 ++++
 rtl/neuron_mac.sv | 183 ++++++++++++++++++
 tb/tb_neuron_mac.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_if.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac_if
// Purpose  : Bundles the pixel input stream, the weight/bias write ports, the
//            activation output stream and the busy flag of neuron_mac.
// Ports    : din/din_valid/din_ready   - pixel byte stream into the neuron
//            w_we/w_addr/w_data        - weight store write port
//            b_we/b_data               - bias register write port
//            dout/dout_valid/dout_ready- activation stream out of the neuron
//            busy                      - neuron is mid-evaluation
// Modports : slave  - the neuron itself
//            master - whatever drives the neuron (stream source, loader, sink)
// Revision : 1.0 - initial release
// ============================================================================
interface neuron_mac_if #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int BIAS_W   = 16,
    parameter int OUT_W    = 8,
    parameter int IDX_W    = 10
);
    logic [DATA_W-1:0]   din;
    logic                din_valid;
    logic                din_ready;
    logic                w_we;
    logic [IDX_W-1:0]    w_addr;
    logic [WEIGHT_W-1:0] w_data;
    logic                b_we;
    logic [BIAS_W-1:0]   b_data;
    logic [OUT_W-1:0]    dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                busy;

    modport slave (
        input  din, din_valid, w_we, w_addr, w_data, b_we, b_data, dout_ready,
        output din_ready, dout, dout_valid, busy
    );

    modport master (
        output din, din_valid, w_we, w_addr, w_data, b_we, b_data, dout_ready,
        input  din_ready, dout, dout_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : neuron_mac
// Purpose  : Single neuron multiply-accumulate. Accepts N_INPUTS unsigned
//            pixel bytes, multiplies each by the signed weight at its index,
//            adds the bias, applies ReLU, shifts right by SHIFT, saturates to
//            OUT_W bits and presents the activation on a valid/ready output.
// Ports    : clk - rising-edge clock
//            rst - asynchronous reset, active low
//            bus - neuron_mac_if.slave (pixel stream, weight/bias writes,
//                  activation stream, busy)
// Options  : ROUND_EN - when defined, round half up before the right shift;
//                       otherwise the shift truncates.
// Revision : 1.0 - initial release
// ============================================================================
module neuron_mac #(
    parameter int N_INPUTS = 784,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int BIAS_W   = 16,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 8,
    parameter int SHIFT    = 0,
    parameter int IDX_W    = 10
) (
    input  logic         clk,
    input  logic         rst,
    neuron_mac_if.slave  bus
);
    localparam int c_pw = DATA_W + WEIGHT_W + 1;          // signed product width
    localparam int c_ew = ACC_W + 1;                      // headroom for rounding
    localparam int c_aw = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0]        c_last = IDX_W'(N_INPUTS - 1);
    localparam logic [IDX_W:0]          c_n    = (IDX_W + 1)'(N_INPUTS);
    localparam logic signed [c_ew-1:0]  c_max  = c_ew'((2 ** OUT_W) - 1);

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_FIN = 2'd1,
        S_OUT = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IDX_W-1:0]           r_cnt;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [BIAS_W-1:0]   r_bias;
    logic [OUT_W-1:0]           r_dout;
    logic                       r_dout_valid;
    logic signed [WEIGHT_W-1:0] r_wmem [0:N_INPUTS-1];

    logic                       w_din_ready;
    logic                       w_accept;
    logic                       w_last;
    logic signed [c_pw-1:0]     w_din_s;
    logic signed [c_pw-1:0]     w_wgt_s;
    logic signed [c_pw-1:0]     w_prod;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [c_ew-1:0]     w_shr;
    logic [OUT_W-1:0]           w_dout_nxt;

    // ------------------------------------------------------------------
    // Weight store: not reset, so a reset between images keeps the model.
    // Out-of-range indices are dropped rather than aliased into the store.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (bus.w_we && ({1'b0, bus.w_addr} < c_n)) begin
            r_wmem[bus.w_addr[c_aw-1:0]] <= $signed(bus.w_data);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_last = (r_cnt == c_last);

    always_comb begin
        w_state_nxt = r_state;
        w_din_ready = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            S_ACC: begin
                w_din_ready = 1'b1;
                w_accept    = bus.din_valid;
                if (bus.din_valid && w_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (bus.dout_ready) begin
                    w_state_nxt = S_ACC;
                end
            end
            default: begin
                w_state_nxt = S_ACC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. The pixel is zero-extended and the weight sign-extended to
    // the full product width so the product is a true signed 17-bit value.
    // The weight is read combinationally, so a same-edge write to the
    // current index only affects the next neuron.
    // ------------------------------------------------------------------
    assign w_din_s = $signed(c_pw'(bus.din));
    assign w_wgt_s = c_pw'(r_wmem[r_cnt[c_aw-1:0]]);
    assign w_prod  = w_din_s * w_wgt_s;
    assign w_sum   = r_acc + ACC_W'(r_bias);

`ifdef ROUND_EN
    localparam logic signed [c_ew-1:0] c_half = (c_ew'(1) << SHIFT) >> 1;
    assign w_shr = (c_ew'(w_sum) + c_half) >>> SHIFT;
`else
    assign w_shr = c_ew'(w_sum) >>> SHIFT;
`endif

    // ReLU then saturate to the unsigned output range
    always_comb begin
        w_dout_nxt = '0;
        if (w_sum < 0) begin
            w_dout_nxt = '0;
        end else if (w_shr > c_max) begin
            w_dout_nxt = OUT_W'(c_max);
        end else begin
            w_dout_nxt = w_shr[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_acc        <= '0;
            r_bias       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            // The FIN computation reads r_bias before this update lands.
            if (bus.b_we) begin
                r_bias <= $signed(bus.b_data);
            end
            unique case (r_state)
                S_ACC: begin
                    if (w_accept) begin
                        r_acc <= r_acc + ACC_W'(w_prod);
                        r_cnt <= w_last ? '0 : r_cnt + IDX_W'(1);
                    end
                end
                S_FIN: begin
                    r_dout       <= w_dout_nxt;
                    r_dout_valid <= 1'b1;
                    r_acc        <= '0;
                end
                S_OUT: begin
                    if (bus.dout_ready) begin
                        r_dout_valid <= 1'b0;
                    end
                end
                default: begin
                    r_dout_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.din_ready  = w_din_ready;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = (r_state != S_ACC) || (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_mac
// Purpose  : Self-checking bench for neuron_mac. Two instances share stimulus:
//            one with SHIFT=0 and one with SHIFT=2, so the shift/rounding path
//            is observed on every neuron evaluation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_mac;
    localparam int N     = 4;
    localparam int IDX_W = 3;

`ifdef ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    neuron_mac_if #(.IDX_W(IDX_W)) bus  ();
    neuron_mac_if #(.IDX_W(IDX_W)) bus2 ();

    assign bus2.din        = bus.din;
    assign bus2.din_valid  = bus.din_valid;
    assign bus2.w_we       = bus.w_we;
    assign bus2.w_addr     = bus.w_addr;
    assign bus2.w_data     = bus.w_data;
    assign bus2.b_we       = bus.b_we;
    assign bus2.b_data     = bus.b_data;
    assign bus2.dout_ready = bus.dout_ready;

    neuron_mac #(.N_INPUTS(N), .SHIFT(0), .IDX_W(IDX_W)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus.slave));
    neuron_mac #(.N_INPUTS(N), .SHIFT(2), .IDX_W(IDX_W)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    typedef struct packed {
        logic [N-1:0][7:0] w;
        logic [N-1:0][7:0] d;
        logic [15:0]       b;
        logic [7:0]        e0;
        logic [7:0]        e2t;
        logic [7:0]        e2r;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int wcur [N];
    int bcur = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int w0, w1, w2, w3, d0, d1, d2, d3,
                                input int b, e0, e2t, e2r);
        vec_t v;
        v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2); v.w[3] = 8'(w3);
        v.d[0] = 8'(d0); v.d[1] = 8'(d1); v.d[2] = 8'(d2); v.d[3] = 8'(d3);
        v.b = 16'(b); v.e0 = 8'(e0); v.e2t = 8'(e2t); v.e2r = 8'(e2r);
        return v;
    endfunction

    // Reference: dot product plus bias, ReLU, optional round, shift, clamp.
    function automatic logic [7:0] model(input logic [N-1:0][7:0] d, input int sh);
        longint s = bcur;
        for (int i = 0; i < N; i++) s += longint'(d[i]) * wcur[i];
        if (s < 0) return 8'd0;
        if (RND && sh > 0) s += (64'sd1 <<< (sh - 1));
        s = s >>> sh;
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    task automatic write_w(input int idx, input int val);
        bus.w_we = 1'b1; bus.w_addr = IDX_W'(idx); bus.w_data = 8'(val);
        @(negedge clk);
        bus.w_we = 1'b0;
        if (idx < N) wcur[idx] = int'($signed(8'(val)));
    endtask

    task automatic write_b(input int val);
        bus.b_we = 1'b1; bus.b_data = 16'(val);
        @(negedge clk);
        bus.b_we = 1'b0;
        bcur = int'($signed(16'(val)));
    endtask

    task automatic load(input logic [N-1:0][7:0] w, input logic [15:0] b);
        for (int i = 0; i < N; i++) write_w(i, int'($signed(w[i])));
        write_b(int'($signed(b)));
    endtask

    // Feeds N bytes (with optional idle gaps), then checks result timing,
    // values, backpressure hold for rdly cycles and the valid drop.
    // wr_at: index whose weight is rewritten in the same cycle it is used.
    // fin_b: bias written during the FIN cycle (ignored when < -40000).
    task automatic run_neuron(input logic [N-1:0][7:0] d, input bit gaps, input int rdly,
                              input logic [7:0] e0, input logic [7:0] e2, input string nm,
                              input int wr_at, input int wr_val, input int fin_b);
        int k = 0;
        int guard = 0;
        bus.dout_ready = 1'b0;
        while (k < N && guard < 100) begin
            guard++;
            bus.w_we = 1'b0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.din_valid = 1'b0;
                bus.din = 8'($urandom);
            end else begin
                bus.din_valid = 1'b1;
                bus.din = d[k];
            end
            if (bus.din_valid && bus.din_ready) begin
                if (k == wr_at) begin
                    bus.w_we = 1'b1; bus.w_addr = IDX_W'(k); bus.w_data = 8'(wr_val);
                end
                k++;
            end
            @(negedge clk);
        end
        bus.din_valid = 1'b0;
        if (bus.w_we) begin
            bus.w_we = 1'b0;
            wcur[wr_at] = int'($signed(8'(wr_val)));
        end
        check({nm, ":accepted"}, k, N);
        if (k < N) return;
        // FIN cycle
        bus.dout_ready = (rdly == 0);
        if (fin_b > -40000) begin
            bus.b_we = 1'b1; bus.b_data = 16'(fin_b);
        end
        check({nm, ":fin_valid"}, bus.dout_valid, 0);
        check({nm, ":fin_ready"}, {bus.din_ready, bus2.din_ready}, 0);
        @(negedge clk);
        if (fin_b > -40000) begin
            bus.b_we = 1'b0;
            bcur = fin_b;
        end
        check({nm, ":valid"}, {bus.dout_valid, bus2.dout_valid}, 2'b11);
        check({nm, ":dout_s0"}, bus.dout, e0);
        check({nm, ":dout_s2"}, bus2.dout, e2);
        if (rdly > 0) begin
            bus.din_valid = 1'b1;
            bus.din = 8'hC8;
            for (int i = 0; i < rdly; i++) begin
                @(negedge clk);
                check({nm, ":hold_valid"}, bus.dout_valid, 1);
                check({nm, ":hold_dout"}, bus.dout, e0);
                check({nm, ":hold_ready"}, bus.din_ready, 0);
            end
            bus.din_valid = 1'b0;
            bus.dout_ready = 1'b1;
        end
        @(negedge clk);
        check({nm, ":valid_drop"}, bus.dout_valid, 0);
        check({nm, ":dout_kept"}, bus.dout, e0);
        bus.dout_ready = 1'b0;
    endtask

    task automatic feed_bytes(input logic [N-1:0][7:0] d, input int cnt);
        int k = 0;
        int guard = 0;
        while (k < cnt && guard < 50) begin
            guard++;
            bus.din_valid = 1'b1;
            bus.din = d[k];
            if (bus.din_ready) k++;
            @(negedge clk);
        end
        bus.din_valid = 1'b0;
        check("feed:accepted", k, cnt);
    endtask

    vec_t tbl [10];
    logic [N-1:0][7:0] d1234;
    logic [N-1:0][7:0] rw;
    logic [N-1:0][7:0] rd;

    initial begin
        bus.din = '0; bus.din_valid = 1'b0; bus.w_we = 1'b0; bus.w_addr = '0;
        bus.w_data = '0; bus.b_we = 1'b0; bus.b_data = '0; bus.dout_ready = 1'b0;
        for (int i = 0; i < N; i++) wcur[i] = 0;

        tbl[0] = mk(1, 2, 3, 4,  1, 2, 3, 4,  0,   30, 7, 8);
        tbl[1] = mk(-1, -1, -1, -1,  5, 5, 5, 5,  0,  0, 0, 0);
        tbl[2] = mk(1, 2, 3, 4,  1, 2, 3, 4,  100,  130, 32, 33);
        tbl[3] = mk(127, 127, 127, 127,  255, 255, 255, 255,  0,  255, 255, 255);
        tbl[4] = mk(1, 2, 3, 4,  1, 2, 3, 4,  -30,  0, 0, 0);
        tbl[5] = mk(1, 2, 3, 4,  1, 2, 3, 4,  -31,  0, 0, 0);
        tbl[6] = mk(1, 0, 0, 0,  255, 0, 0, 0,  0,  255, 63, 64);
        tbl[7] = mk(1, 0, 0, 0,  255, 0, 0, 0,  1,  255, 64, 64);
        tbl[8] = mk(1, 0, 0, 0,  2, 0, 0, 0,  0,  2, 0, 1);
        tbl[9] = mk(-128, -128, -128, -128,  255, 255, 255, 255,  32767,  0, 0, 0);
        d1234 = tbl[0].d;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst:dout_valid", {bus.dout_valid, bus2.dout_valid}, 0);
        check("rst:dout", bus.dout, 0);
        check("rst:din_ready", bus.din_ready, 1);
        check("rst:busy", {bus.busy, bus2.busy}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed table
        for (int i = 0; i < 10; i++) begin
            load(tbl[i].w, tbl[i].b);
            run_neuron(tbl[i].d, 1'b0, 0, tbl[i].e0, RND ? tbl[i].e2r : tbl[i].e2t,
                       $sformatf("vec%0d", i), -1, 0, -50000);
        end

        // Backpressure with din_valid held high, then a fresh sum
        load(tbl[0].w, 16'd0);
        run_neuron(d1234, 1'b0, 5, 8'd30, RND ? 8'd8 : 8'd7, "bp", -1, 0, -50000);
        run_neuron(d1234, 1'b0, 0, 8'd30, RND ? 8'd8 : 8'd7, "bp_next", -1, 0, -50000);

        // Out-of-range weight writes are ignored
        write_w(4, 50);
        write_w(7, -100);
        run_neuron(d1234, 1'b0, 0, 8'd30, RND ? 8'd8 : 8'd7, "oor", -1, 0, -50000);

        // Same-cycle weight write uses the old weight; bias write in FIN uses old bias
        run_neuron(d1234, 1'b0, 0, 8'd30, RND ? 8'd8 : 8'd7, "wr_same", 3, 10, 100);
        run_neuron(d1234, 1'b0, 0, 8'd154, RND ? 8'd39 : 8'd38, "wr_after", -1, 0, -50000);
        write_w(3, 4);
        write_b(0);

        // Reset after two bytes: partial sum discarded, weights retained
        feed_bytes(d1234, 2);
        check("rst_mid:busy_before", bus.busy, 1);
        #1 rst = 1'b0;
        #1;
        check("rst_mid:dout_valid", bus.dout_valid, 0);
        check("rst_mid:busy", bus.busy, 0);
        check("rst_mid:din_ready", bus.din_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        bcur = 0;
        @(negedge clk);
        run_neuron(d1234, 1'b0, 0, 8'd30, RND ? 8'd8 : 8'd7, "rst_mid_run", -1, 0, -50000);

        // Reset with a result pending
        feed_bytes(d1234, N);
        @(negedge clk);
        check("rst_pend:valid_before", bus.dout_valid, 1);
        #1 rst = 1'b0;
        #1;
        check("rst_pend:dout_valid", bus.dout_valid, 0);
        check("rst_pend:dout", bus.dout, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomised against the reference model
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) begin
                rw[i] = 8'($urandom_range(0, 167) - 40);
                rd[i] = 8'($urandom_range(0, 255));
            end
            load(rw, 16'($urandom_range(0, 4000) - 2000));
            run_neuron(rd, 1'b1, int'($urandom_range(0, 3)), model(rd, 0), model(rd, 2),
                       $sformatf("rnd%0d", t), -1, 0, -50000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
